// File: rtl/tmds_channel_decoder_if.sv
// rtl/tmds_channel_decoder_if.sv - TMDS lane decoder bus: serial lane in, decoded word out
//
// Signals:
//   serial_in   lane bit from the input sampler, one per bit clock
//   data_out    decoded pixel byte (valid when de_out=1)
//   de_out      1 = data word, 0 = control word
//   c0_out      decoded C0 (HSYNC), held during data
//   c1_out      decoded C1 (VSYNC), held during data
//   word_valid  one-cycle pulse per decoded word
//   locked      word alignment established
//   err_cnt     misaligned control-token count (0 unless TMDS_DEC_ERR_CNT_EN)
//
// Modports:
//   master  decoder side (consumes serial_in, drives the decoded outputs)
//   slave   sampler / pixel side (drives serial_in, observes the outputs)

interface tmds_channel_decoder_if;
    logic        serial_in;
    logic [7:0]  data_out;
    logic        de_out;
    logic        c0_out;
    logic        c1_out;
    logic        word_valid;
    logic        locked;
    logic [15:0] err_cnt;

    modport master (
        input  serial_in,
        output data_out, de_out, c0_out, c1_out, word_valid, locked, err_cnt
    );

    modport slave (
        output serial_in,
        input  data_out, de_out, c0_out, c1_out, word_valid, locked, err_cnt
    );
endinterface

// File: rtl/tmds_channel_decoder.sv
// rtl/tmds_channel_decoder.sv - TMDS lane word aligner and 10b-to-8b decoder
//
// Purpose: shifts in one TMDS lane bit per clock, aligns to 10-bit word
// boundaries using the four control tokens, and decodes each aligned word
// into a pixel byte or an {C1,C0} control pair. One word out per 10 clocks
// once locked.
//
// Ports:
//   clk    TMDS bit clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    tmds_channel_decoder_if.master (serial_in in, decoded outputs out)
//
// Parameters:
//   LOCK_TOKENS  consecutive aligned control tokens needed to lock
//   MAX_GAP      aligned words without a control token before lock is dropped
//
// Optional feature: define TMDS_DEC_ERR_CNT_EN to build the saturating
// misaligned-token counter on err_cnt; otherwise err_cnt is tied to 0.

module tmds_channel_decoder #(
    parameter int LOCK_TOKENS = 8,
    parameter int MAX_GAP     = 2000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    tmds_channel_decoder_if.master        bus
);
    localparam int TW = $clog2(LOCK_TOKENS + 1);

    localparam logic [1:0] ST_SEARCH = 2'd0;
    localparam logic [1:0] ST_VERIFY = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    localparam logic [9:0] TOK_00 = 10'b0010101011;
    localparam logic [9:0] TOK_01 = 10'b1101010100;
    localparam logic [9:0] TOK_10 = 10'b0010101010;
    localparam logic [9:0] TOK_11 = 10'b1101010101;

    logic [9:0]    r_sr;
    logic [3:0]    r_ph;
    logic [1:0]    r_state;
    logic [TW-1:0] r_tok_cnt;
    logic [11:0]   r_gap_cnt;
    logic [7:0]    r_data;
    logic          r_de;
    logic          r_c0;
    logic          r_c1;
    logic          r_word_valid;
    logic          r_locked;

    logic          w_is_tok;
    logic [1:0]    w_tok_c;
    logic          w_boundary;
    logic [7:0]    w_d;
    logic [7:0]    w_dec;

    // The word under test is always the registered shift register, so the
    // cycle after a word's last bit is sampled is its boundary cycle.
    always_comb begin
        w_is_tok = 1'b1;
        w_tok_c  = 2'b00;
        case (r_sr)
            TOK_00:  w_tok_c = 2'b00;
            TOK_01:  w_tok_c = 2'b01;
            TOK_10:  w_tok_c = 2'b10;
            TOK_11:  w_tok_c = 2'b11;
            default: w_is_tok = 1'b0;
        endcase
    end

    assign w_boundary = (r_ph == 4'd0);

    always_comb begin
        w_d      = r_sr[9] ? ~r_sr[7:0] : r_sr[7:0];
        w_dec    = 8'd0;
        w_dec[0] = w_d[0] ^ ~r_sr[8];
        for (int i = 1; i < 8; i++) begin
            w_dec[i] = w_d[i] ^ w_d[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sr         <= '0;
            r_ph         <= '0;
            r_state      <= ST_SEARCH;
            r_tok_cnt    <= '0;
            r_gap_cnt    <= '0;
            r_data       <= '0;
            r_de         <= 1'b0;
            r_c0         <= 1'b0;
            r_c1         <= 1'b0;
            r_word_valid <= 1'b0;
            r_locked     <= 1'b0;
        end else begin
            r_sr         <= {r_sr[8:0], bus.serial_in};
            r_ph         <= (r_ph == 4'd9) ? 4'd0 : r_ph + 4'd1;
            r_word_valid <= 1'b0;
            case (r_state)
                ST_SEARCH: begin
                    if (w_is_tok) begin
                        // Treat this cycle as the boundary: next cycle is phase 1.
                        r_ph      <= 4'd1;
                        r_tok_cnt <= TW'(1);
                        r_state   <= ST_VERIFY;
                    end
                end
                ST_VERIFY: begin
                    if (w_boundary) begin
                        if (!w_is_tok) begin
                            r_state   <= ST_SEARCH;
                            r_tok_cnt <= '0;
                        end else if (r_tok_cnt == TW'(LOCK_TOKENS - 1)) begin
                            // The locking token itself is the first decoded word.
                            r_state      <= ST_LOCKED;
                            r_locked     <= 1'b1;
                            r_tok_cnt    <= '0;
                            r_gap_cnt    <= '0;
                            r_word_valid <= 1'b1;
                            r_de         <= 1'b0;
                            {r_c1, r_c0} <= w_tok_c;
                        end else begin
                            r_tok_cnt <= r_tok_cnt + TW'(1);
                        end
                    end
                end
                ST_LOCKED: begin
                    if (w_boundary) begin
                        if (w_is_tok) begin
                            r_gap_cnt    <= '0;
                            r_word_valid <= 1'b1;
                            r_de         <= 1'b0;
                            {r_c1, r_c0} <= w_tok_c;
                        end else if (r_gap_cnt == 12'(MAX_GAP - 1)) begin
                            // Gap limit reached: this word is dropped, not decoded.
                            r_state   <= ST_SEARCH;
                            r_locked  <= 1'b0;
                            r_gap_cnt <= '0;
                        end else begin
                            r_gap_cnt    <= r_gap_cnt + 12'd1;
                            r_word_valid <= 1'b1;
                            r_de         <= 1'b1;
                            r_data       <= w_dec;
                        end
                    end
                end
                default: r_state <= ST_SEARCH;
            endcase
        end
    end

`ifdef TMDS_DEC_ERR_CNT_EN
    logic [15:0] r_err_cnt;

    // A token seen off-boundary while locked means the lane slipped bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
        end else if ((r_state == ST_LOCKED) && !w_boundary && w_is_tok &&
                     (r_err_cnt != 16'hFFFF)) begin
            r_err_cnt <= r_err_cnt + 16'd1;
        end
    end

    assign bus.err_cnt = r_err_cnt;
`else
    assign bus.err_cnt = 16'd0;
`endif

    assign bus.data_out   = r_data;
    assign bus.de_out     = r_de;
    assign bus.c0_out     = r_c0;
    assign bus.c1_out     = r_c1;
    assign bus.word_valid = r_word_valid;
    assign bus.locked     = r_locked;

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// tb/tb_tmds_channel_decoder.sv - self-checking bench for tmds_channel_decoder

module tb_tmds_channel_decoder;
    localparam logic [9:0]  TOK00    = 10'b0010101011;
    localparam logic [9:0]  TOK01    = 10'b1101010100;
    localparam logic [9:0]  TOK10    = 10'b0010101010;
    localparam logic [9:0]  TOK11    = 10'b1101010101;
    // 8'hA5 encoded four ways: {q9,q8} = 01, 11, 00, 10
    localparam logic [9:0]  W_A5_01  = 10'b0101100011;
    localparam logic [9:0]  W_A5_11  = 10'b1110011100;
    localparam logic [9:0]  W_A5_00  = 10'b0010011100;
    localparam logic [9:0]  W_A5_10  = 10'b1001100011;
    localparam logic [12:0] PRE_BITS = 13'b1110001110001;

    typedef struct {
        logic       de;
        logic [7:0] data;
        logic [1:0] c;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   last_wv_cyc = -1;
    int   wv_seen = 0;
    logic prev_locked = 1'b0;
    logic sb_on = 1'b0;
    logic [7:0] last_data;
    logic [1:0] last_c;
    exp_t exp_q[$];

    tmds_channel_decoder_if bus();

    tmds_channel_decoder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] enc(input logic [7:0] b, input logic q8, input logic q9);
        logic [7:0] d;
        d[0] = b[0] ^ ~q8;
        for (int i = 1; i < 8; i++) d[i] = b[i] ^ d[i-1];
        return {q9, q8, (q9 ? ~d : d)};
    endfunction

    function automatic logic is_tok(input logic [9:0] w);
        return (w == TOK00) || (w == TOK01) || (w == TOK10) || (w == TOK11);
    endfunction

    task automatic push_ctrl(input logic [1:0] c);
        exp_t e;
        e.de = 1'b0; e.data = last_data; e.c = c;
        exp_q.push_back(e);
        last_c = c;
    endtask

    task automatic push_data(input logic [7:0] b);
        exp_t e;
        e.de = 1'b1; e.data = b; e.c = last_c;
        exp_q.push_back(e);
        last_data = b;
    endtask

    task automatic send_bit(input logic b);
        bus.serial_in = b;
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [9:0] w);
        for (int b = 9; b >= 0; b--) send_bit(w[b]);
    endtask

    task automatic send_pre();
        logic [12:0] p;
        p = PRE_BITS;
        for (int b = 12; b >= 0; b--) send_bit(p[b]);
    endtask

    task automatic lock_seq(input logic [9:0] tok, input logic [1:0] c);
        send_pre();
        repeat (7) send_word(tok);
        push_ctrl(c);
        send_word(tok);
    endtask

    // Output monitor / scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.locked && !prev_locked) chk("lock_rise_with_wv", bus.word_valid, 1);
            if (!bus.locked) last_wv_cyc = -1;
            if (bus.word_valid) begin
                wv_seen++;
                chk("wv_while_locked", bus.locked, 1);
                if (sb_on) begin
                    if (exp_q.size() == 0) begin
                        chk("sb_unexpected_word", exp_q.size(), 1);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        chk("sb_de", bus.de_out, e.de);
                        chk("sb_data", bus.data_out, e.data);
                        chk("sb_c", {bus.c1_out, bus.c0_out}, e.c);
                    end
                    if (last_wv_cyc >= 0) chk("wv_spacing", cyc - last_wv_cyc, 10);
                end
                last_wv_cyc = cyc;
            end
        end
        prev_locked = bus.locked;
    end

    initial begin
        logic [9:0] t;
        rst_n         = 1'b0;
        bus.serial_in = 1'b0;
        last_data     = 8'h00;
        last_c        = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data", bus.data_out, 0);
        chk("rst_de", bus.de_out, 0);
        chk("rst_c0", bus.c0_out, 0);
        chk("rst_c1", bus.c1_out, 0);
        chk("rst_wv", bus.word_valid, 0);
        chk("rst_locked", bus.locked, 0);
        chk("rst_err_cnt", bus.err_cnt, 0);
        rst_n = 1'b1;

        // Lock on 00 tokens after unaligned leading bits.
        sb_on = 1'b1;
        lock_seq(TOK00, 2'b00);
        chk("locked_before_first_wv", bus.locked, 0);
        push_ctrl(2'b00);
        send_word(TOK00);
        chk("locked_after_lock", bus.locked, 1);

        // 8'hA5 through every {q9,q8} combination.
        push_data(8'hA5); send_word(W_A5_01);
        push_data(8'hA5); send_word(W_A5_11);
        push_data(8'hA5); send_word(W_A5_00);
        push_data(8'hA5); send_word(W_A5_10);
        push_ctrl(2'b01); send_word(TOK01);
        push_ctrl(2'b10); send_word(TOK10);
        for (int k = 0; k < 6; k++) begin
            logic [7:0] b;
            logic [9:0] w;
            b = 8'($urandom);
            w = enc(b, 1'($urandom), 1'($urandom));
            if (is_tok(w)) w[9] = ~w[9];
            push_data(b);
            send_word(w);
        end
        push_ctrl(2'b11); send_word(TOK11);

        // Asynchronous reset while a data word is being presented.
        send_word(W_A5_01);
        sb_on = 1'b0;
        chk("sb_drained_1", exp_q.size(), 0);
        send_bit(1'b0);
        chk("pre_reset_wv", bus.word_valid, 1);
        chk("pre_reset_de", bus.de_out, 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_locked", bus.locked, 0);
        chk("async_rst_wv", bus.word_valid, 0);
        chk("async_rst_de", bus.de_out, 0);
        chk("async_rst_data", bus.data_out, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Seven tokens then a data word must not lock.
        last_data = 8'h00;
        last_c    = 2'b00;
        sb_on     = 1'b1;
        wv_seen   = 0;
        send_pre();
        repeat (7) send_word(TOK00);
        send_word(W_A5_01);
        chk("no_lock_7_tokens", bus.locked, 0);
        chk("no_wv_7_tokens", wv_seen, 0);
        repeat (7) send_word(TOK00);
        chk("no_lock_mid_relock", bus.locked, 0);
        push_ctrl(2'b00);
        send_word(TOK00);

        // 2000 words without a token drop lock; the 2000th is not output.
        for (int k = 0; k < 2000; k++) begin
            if (k < 1999) push_data(8'hA5);
            send_word(W_A5_01);
        end
        chk("locked_before_gap_drop", bus.locked, 1);
        t = TOK11;
        send_bit(t[9]);
        chk("locked_after_gap_drop", bus.locked, 0);
        chk("wv_after_gap_drop", bus.word_valid, 0);
        for (int b = 8; b >= 0; b--) send_bit(t[b]);
        repeat (6) send_word(TOK11);
        push_ctrl(2'b11);
        send_word(TOK11);
        push_ctrl(2'b11);
        send_word(TOK11);
        chk("relock_after_gap", bus.locked, 1);
        send_bit(1'b1);
        @(negedge clk);
        #1;
        chk("sb_drained_2", exp_q.size(), 0);
        sb_on = 1'b0;

        // Misaligned token burst after a one-bit slip.
        rst_n = 1'b0;
        #1;
        chk("err_cnt_reset", bus.err_cnt, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        lock_seq(TOK00, 2'b00);
        repeat (2) send_word(TOK00);
        send_bit(1'b1);
        repeat (5) send_word(TOK00);
        repeat (2) @(posedge clk);
        #1;
`ifdef TMDS_DEC_ERR_CNT_EN
        chk("err_cnt_burst", bus.err_cnt, 5);
`else
        chk("err_cnt_burst", bus.err_cnt, 0);
`endif
        chk("locked_through_slip", bus.locked, 1);
        exp_q.delete();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
